// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among the pixel-layer
// requesters, returning each read's data with a one-hot valid to its issuer.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    line_start,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_rd,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [15:0]             grant_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  logic [ROM_LAT-1:0] tag_vld_p;
  logic [PTR_W-1:0]   tag_idx_p [ROM_LAT];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  // Arbitration: search from ptr upward with wrap; the modulo also keeps any
  // stray pointer value inside the legal requester range.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % N_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt      = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    rom_addr = gnt_any ? addr_arr[gnt_idx] : '0;
    rom_rd   = gnt_any;
  end

  // Stage p0..p(ROM_LAT-1): tag valid bits follow the ROM access, last stage
  // lines up with rom_data and loads the return registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr       <= '0;
      grant_cnt <= '0;
      tag_vld_p <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      if (line_start) begin
        ptr       <= '0;
        grant_cnt <= '0;
      end else if (gnt_any) begin
        ptr       <= (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        grant_cnt <= sat_inc(grant_cnt);
      end
      tag_vld_p[0] <= gnt_any;
      for (int s = 1; s < ROM_LAT; s++) tag_vld_p[s] <= tag_vld_p[s-1];
      if (tag_vld_p[ROM_LAT-1]) begin
        rd_valid <= N_REQ'(1) << tag_idx_p[ROM_LAT-1];
        rd_data  <= rom_data;
      end else begin
        rd_valid <= '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    tag_idx_p[0] <= gnt_idx;
    for (int s = 1; s < ROM_LAT; s++) tag_idx_p[s] <= tag_idx_p[s-1];
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares a single-port on-chip sprite ROM among the pixel-layer requesters (player1, player2, bullets, HP_bar) that feed color_mapper. Each cycle it grants at most one ROM read by round-robin and carries the requester index alongside the ROM access. It then returns the ROM data with a one-hot valid to the requester that issued the read. It runs on the 50 MHz system clock and sits between the sprite modules and the ROM.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 15, ROM word address width
- DATA_W, 4, ROM data width (palette index)
- ROM_LAT, 2, ROM read latency in cycles (1..4), address to data

Ports:
- Clk  input  1  system clock; all state on rising edge
- Reset  input  1  synchronous, active-high reset
- line_start  input  1  one-cycle pulse at start of each scanline; resets round-robin pointer
- req  input  N_REQ  per-requester read request, held until granted
- req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- gnt  output  N_REQ  one-hot grant, combinational, same cycle as req
- rom_rd  output  1  ROM read strobe (= |gnt)
- rom_addr  output  ADDR_W  address of granted requester; 0 when no grant
- rom_data  input  DATA_W  ROM output, valid ROM_LAT cycles after rom_rd
- rd_valid  output  N_REQ  registered one-hot, data return for requester i
- rd_data  output  DATA_W  registered returned data
- grant_cnt  output  16  registered count of grants since the last line_start, saturating

## Operation
- State: round-robin pointer ptr (log2 N_REQ bits), tag pipeline of ROM_LAT stages {valid, index}, output registers, grant_cnt.
- Arbitration: search starts at ptr, ascending with wrap. The first i with req[i]=1 gets gnt[i]=1. No req means gnt=0 and rom_rd=0.
- Pointer update: on a grant to i, ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- line_start has priority over the grant-driven update: ptr <= 0 and grant_cnt <= 0. The arbitration result in that same cycle still uses the old ptr and is still issued.
- Tag pipeline: stage0 <= {rom_rd, granted index}, and each stage shifts by one every cycle. The pipeline never stalls.
- Return: when the last stage is valid with index k, the next edge sets rd_valid <= onehot(k) and rd_data <= rom_data. Otherwise rd_valid <= 0 and rd_data holds.
- grant_cnt increments on every grant and saturates at 16'hFFFF. If line_start and a grant occur in the same cycle, grant_cnt <= 0.
- Requester contract:
  - req_addr[i] stays stable while req[i]=1.
  - The requester drops req for at least the cycle after gnt, or re-asserts it for a new read.
  - A requester may keep req high to issue back-to-back reads. Each gnt is one read.
- Fairness: a continuously requesting requester is granted within N_REQ cycles of asserting req, unless line_start intervenes.

## Timing
- Read latency: gnt in cycle T, rd_valid/rd_data visible in cycle T+ROM_LAT+1.
- Throughput: one read per cycle, aggregate across requesters.
- Reset values:
  - ptr=0, all tag stages invalid.
  - rd_valid=0, rd_data=0, grant_cnt=0.
  - gnt, rom_rd and rom_addr follow req combinationally. They are 0 while req=0.
- Reset mid-operation: in-flight tags are discarded. No rd_valid is asserted for reads issued before Reset, even if the ROM returns data.
- Reset held: arbitration outputs stay combinational, but no tags enter the pipeline and ptr stays 0.
- Simultaneous requests: exactly one gnt bit per cycle. Never more than one rd_valid bit.
- Wrap: with ptr=N_REQ-1 and a grant to N_REQ-1, ptr becomes 0.
- Out-of-range: an index >= N_REQ never appears. ptr is masked to a legal value after reset.

## Test plan
- Reset, then req=4'b0001, addr0=15'h0123, ROM returns 4'hA: gnt=0001 in cycle 0; rom_addr=0x0123; rd_valid=0001 and rd_data=A in cycle 3 (ROM_LAT=2).
- req=4'b1111 held for 8 cycles after reset: grants 0,1,2,3,0,1,2,3; rd_valid repeats that pattern starting 3 cycles later; grant_cnt=8.
- req=4'b1010 with ptr=2: gnt=1000, then gnt=0010, then gnt=1000; requesters 0 and 2 never granted.
- line_start pulses while ptr=3 and req=4'b1001: that cycle grants 3, then ptr=0 and the next cycle grants 0; grant_cnt=0 after the pulse, 1 after the next grant.
- Grant issued, then Reset asserted one cycle later: no rd_valid in any following cycle; ptr=0, grant_cnt=0.
- 70000 consecutive grants without line_start: grant_cnt saturates at 16'hFFFF and holds.
